// File: rtl/hist_builder_pp.sv
// Ping-pong dToF histogram builder.
// Hits accumulate into the filling bank for ACQ_NUM acquisitions, then the
// banks swap and the finished bank is streamed out bin-by-bin over a
// valid/ready port, each entry being cleared as it is handed off, while the
// other bank keeps filling. A frame that completes during readout defers its
// swap until the reader returns to idle and flags a sticky overrun.
module hist_builder_pp #(
  parameter int BIN_W   = 6,
  parameter int CNT_W   = 16,
  parameter int ACQ_NUM = 1000,
  parameter int ACQ_W   = 20
) (
  input  logic             clk,
  input  logic             res,
  input  logic             hit_vld,
  input  logic [BIN_W-1:0] hit_bin,
  input  logic             acq_end,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             bank_sel,
  output logic             frame_done,
  output logic             overrun
);

  localparam int               NBIN     = 1 << BIN_W;
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
  localparam logic [ACQ_W-1:0] ACQ_HOLD = ACQ_W'(ACQ_NUM);
  localparam logic [BIN_W-1:0] BIN_MAX  = BIN_W'(NBIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [CNT_W-1:0] r_bank [0:1][0:NBIN-1];
  logic             r_bank_sel;
  logic [ACQ_W-1:0] r_acq_cnt;
  logic             r_pending;
  logic             r_overrun;
  logic             r_frame_done;
  logic             r_rd_valid;
  logic [BIN_W-1:0] r_rd_bin;
  logic [CNT_W-1:0] r_rd_count;
  logic             r_rd_last;

  logic             w_rd_sel;
  logic [CNT_W-1:0] w_hit_cur;
  logic [CNT_W-1:0] w_hit_inc;
  logic [CNT_W-1:0] w_first_cnt;
  logic [BIN_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_hs;
  logic             w_clear;
  logic             w_frame_end;
  logic             w_swap_req;
  logic             w_swap;
  logic             w_defer;

  // The bank being read is always the one not selected for filling.
  assign w_rd_sel  = ~r_bank_sel;

  // Saturating increment of the addressed bin in the filling bank.
  assign w_hit_cur = r_bank[r_bank_sel][hit_bin];
  assign w_hit_inc = (w_hit_cur == CNT_MAX) ? w_hit_cur : w_hit_cur + CNT_W'(1);

  // Bin 0 is loaded on the swap edge, the same edge that may still count a
  // hit into it, so forward that hit into the first beat.
  assign w_first_cnt = (hit_vld && hit_bin == '0) ? w_hit_inc : r_bank[r_bank_sel][0];

  assign w_rd_next  = r_rd_bin + BIN_W'(1);
  assign w_next_cnt = r_bank[w_rd_sel][w_rd_next];
  assign w_hs       = r_rd_valid & rd_ready;
  assign w_clear    = (r_state == ST_STREAM) & w_hs;

  // A pending swap masks further acq_end pulses until it is taken.
  assign w_frame_end = acq_end & ~r_pending & (r_acq_cnt == ACQ_LAST);
  assign w_swap_req  = w_frame_end | r_pending;
  assign w_swap      = w_swap_req & (r_state == ST_IDLE);
  assign w_defer     = w_swap_req & (r_state != ST_IDLE);

  // Read FSM next-state: start streaming on a swap, stop after the last bin.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_swap)              w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_hs && r_rd_last)   w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge res) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Frame control: acquisition counting, bank swap, deferred swap and overrun.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_bank_sel   <= 1'b0;
      r_acq_cnt    <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_swap;
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
        r_acq_cnt  <= '0;
        r_pending  <= 1'b0;
      end else if (w_defer) begin
        r_pending  <= 1'b1;
        r_overrun  <= 1'b1;
        r_acq_cnt  <= ACQ_HOLD;
      end else if (acq_end) begin
        r_acq_cnt  <= r_acq_cnt + ACQ_W'(1);
      end
    end
  end

  // Readout port: load bin 0 on swap, advance on each handshake, drop after last.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rd_valid <= 1'b0;
      r_rd_bin   <= '0;
      r_rd_count <= '0;
      r_rd_last  <= 1'b0;
    end else if (w_swap) begin
      r_rd_valid <= 1'b1;
      r_rd_bin   <= '0;
      r_rd_count <= w_first_cnt;
      r_rd_last  <= 1'b0;
    end else if (w_clear) begin
      if (r_rd_last) begin
        r_rd_valid <= 1'b0;
        r_rd_bin   <= '0;
        r_rd_count <= '0;
        r_rd_last  <= 1'b0;
      end else begin
        r_rd_bin   <= w_rd_next;
        r_rd_count <= w_next_cnt;
        r_rd_last  <= (w_rd_next == BIN_MAX);
      end
    end
  end

  // Histogram banks: hits count into the filling bank, handshakes clear the read bank.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      // NOTE: the banks are flop arrays, not RAM, so reset can and must clear every count.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NBIN; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      if (hit_vld) r_bank[r_bank_sel][hit_bin] <= w_hit_inc;
      if (w_clear) r_bank[w_rd_sel][r_rd_bin]  <= '0;
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_bin     = r_rd_bin;
  assign rd_count   = r_rd_count;
  assign rd_last    = r_rd_last;
  assign bank_sel   = r_bank_sel;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_hist_builder_pp.sv
// Self-checking bench for hist_builder_pp with BIN_W=3, CNT_W=4, ACQ_NUM=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hist_builder_pp;

  localparam int BIN_W   = 3;
  localparam int CNT_W   = 4;
  localparam int ACQ_NUM = 4;
  localparam int ACQ_W   = 4;
  localparam int NBIN    = 8;

  typedef struct packed {
    logic [NBIN-1:0][4:0] hits;
    logic [NBIN-1:0][3:0] cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             res;
  logic             hit_vld;
  logic [BIN_W-1:0] hit_bin;
  logic             acq_end;
  logic             rd_ready;
  logic             rd_valid;
  logic [BIN_W-1:0] rd_bin;
  logic [CNT_W-1:0] rd_count;
  logic             rd_last;
  logic             bank_sel;
  logic             frame_done;
  logic             overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_sel;

  hist_builder_pp #(
    .BIN_W(BIN_W), .CNT_W(CNT_W), .ACQ_NUM(ACQ_NUM), .ACQ_W(ACQ_W)
  ) dut (
    .clk(clk), .res(res), .hit_vld(hit_vld), .hit_bin(hit_bin),
    .acq_end(acq_end), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last),
    .bank_sel(bank_sel), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hit(input int bin);
    hit_vld = 1'b1;
    hit_bin = BIN_W'(bin);
    tick();
    hit_vld = 1'b0;
  endtask

  // n acq_end pulses separated by idle cycles; returns just after the last edge.
  task automatic acq_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      acq_end = 1'b1;
      tick();
      acq_end = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  task automatic swap_check(input string tag);
    exp_sel = ~exp_sel;
    check($sformatf("%s frame_done", tag), frame_done, 1);
    check($sformatf("%s bank_sel", tag), bank_sel, exp_sel);
  endtask

  // Read beats first..NBIN-1 with rd_ready held high; clears hit_vld after one cycle.
  task automatic read_frame(input string tag, input logic [NBIN-1:0][3:0] exp, input int first);
    rd_ready = 1'b1;
    for (int b = first; b < NBIN; b++) begin
      check($sformatf("%s b%0d valid", tag, b), rd_valid, 1);
      check($sformatf("%s b%0d bin", tag, b), rd_bin, b);
      check($sformatf("%s b%0d count", tag, b), rd_count, exp[b]);
      check($sformatf("%s b%0d last", tag, b), rd_last, (b == NBIN - 1));
      if (b > 0) check($sformatf("%s b%0d frame_done", tag, b), frame_done, 0);
      tick();
      hit_vld = 1'b0;
    end
    check($sformatf("%s end valid", tag), rd_valid, 0);
  endtask

  task automatic reset_outputs_check(input string tag);
    check($sformatf("%s rd_valid", tag), rd_valid, 0);
    check($sformatf("%s rd_bin", tag), rd_bin, 0);
    check($sformatf("%s rd_count", tag), rd_count, 0);
    check($sformatf("%s rd_last", tag), rd_last, 0);
    check($sformatf("%s bank_sel", tag), bank_sel, 0);
    check($sformatf("%s frame_done", tag), frame_done, 0);
    check($sformatf("%s overrun", tag), overrun, 0);
  endtask

  initial begin
    vec_t                 vecs [4];
    logic [NBIN-1:0][3:0] e;
    logic [NBIN-1:0][3:0] zero;
    int                   beat;
    int                   bb;
    logic                 stalled;
    logic                 hs;
    logic [BIN_W-1:0]     s_bin;
    logic [CNT_W-1:0]     s_cnt;
    logic                 s_last;

    // Frame table: hits injected per bin and the counts expected on readout.
    zero = '0;
    vecs[0] = '0;                        // basic frame
    vecs[0].hits[2] = 5'd5;  vecs[0].cnt[2] = 4'd5;
    vecs[0].hits[7] = 5'd1;  vecs[0].cnt[7] = 4'd1;
    vecs[1] = '0;                        // saturation around the 15 limit
    vecs[1].hits[3] = 5'd20; vecs[1].cnt[3] = 4'd15;
    vecs[1].hits[0] = 5'd15; vecs[1].cnt[0] = 4'd15;
    vecs[1].hits[1] = 5'd14; vecs[1].cnt[1] = 4'd14;
    vecs[2] = '0;                        // every bin hit, last bin saturated
    for (int i = 0; i < NBIN; i++) begin
      vecs[2].hits[i] = 5'd1;
      vecs[2].cnt[i]  = 4'd1;
    end
    vecs[2].hits[7] = 5'd17; vecs[2].cnt[7] = 4'd15;
    vecs[3] = '0;                        // empty frame: previous reads left zeros

    res = 1'b1; hit_vld = 1'b0; hit_bin = '0; acq_end = 1'b0; rd_ready = 1'b0;
    exp_sel = 1'b0;
    tick(); tick();
    reset_outputs_check("reset");
    res = 1'b0;
    tick();

    // Table-driven full frames.
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < NBIN; b++) begin
        repeat (int'(vecs[v].hits[b])) hit(b);
      end
      acq_pulses(ACQ_NUM);
      swap_check($sformatf("vec%0d", v));
      read_frame($sformatf("vec%0d", v), vecs[v].cnt, 0);
    end

    // Hit on the swapping acq_end goes to the old bank, next-cycle hit to the new one.
    for (int k = 0; k < 2; k++) begin
      bb = (k == 0) ? 1 : 0;
      acq_pulses(ACQ_NUM - 1);
      tick();
      acq_end = 1'b1; hit_vld = 1'b1; hit_bin = BIN_W'(bb);
      tick();
      acq_end = 1'b0;
      swap_check($sformatf("bnd%0d", bb));
      e = '0; e[bb] = 4'd1;
      hit_vld = 1'b1; hit_bin = BIN_W'(bb);
      read_frame($sformatf("bnd%0d old", bb), e, 0);
      acq_pulses(ACQ_NUM);
      swap_check($sformatf("bnd%0d new", bb));
      read_frame($sformatf("bnd%0d new", bb), e, 0);
    end

    // Backpressure: bin k holds k counts; random stalls must not disturb the stream.
    for (int b = 0; b < NBIN; b++) repeat (b) hit(b);
    acq_pulses(ACQ_NUM);
    swap_check("bp");
    beat = 0; stalled = 1'b0; s_bin = '0; s_cnt = '0; s_last = 1'b0;
    for (int cyc = 0; cyc < 200 && beat < NBIN; cyc++) begin
      if (stalled) begin
        check("bp stall bin", rd_bin, s_bin);
        check("bp stall count", rd_count, s_cnt);
        check("bp stall last", rd_last, s_last);
      end
      check("bp valid", rd_valid, 1);
      check("bp bin", rd_bin, beat);
      check("bp count", rd_count, beat);
      check("bp last", rd_last, (beat == NBIN - 1));
      rd_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      stalled = rd_valid & ~rd_ready;
      hs      = rd_valid & rd_ready;
      s_bin = rd_bin; s_cnt = rd_count; s_last = rd_last;
      tick();
      if (hs) beat++;
    end
    check("bp beats", beat, NBIN);
    check("bp end valid", rd_valid, 0);
    for (int f = 0; f < 2; f++) begin
      acq_pulses(ACQ_NUM);
      swap_check($sformatf("bp clr%0d", f));
      read_frame($sformatf("bp clr%0d", f), zero, 0);
    end

    // Overrun: the next frame completes while the reader is stalled.
    repeat (2) hit(4);
    acq_pulses(ACQ_NUM);
    swap_check("ovr first");
    rd_ready = 1'b0;
    repeat (3) hit(5);
    acq_pulses(ACQ_NUM);
    check("ovr overrun", overrun, 1);
    check("ovr deferred frame_done", frame_done, 0);
    check("ovr deferred bank_sel", bank_sel, exp_sel);
    check("ovr stalled bin", rd_bin, 0);
    repeat (2) hit(5);
    acq_pulses(2);
    check("ovr extra acq frame_done", frame_done, 0);
    check("ovr extra acq bank_sel", bank_sel, exp_sel);
    e = '0; e[4] = 4'd2;
    read_frame("ovr read1", e, 0);
    check("ovr idle frame_done", frame_done, 0);
    check("ovr idle bank_sel", bank_sel, exp_sel);
    tick();
    swap_check("ovr late swap");
    e = '0; e[5] = 4'd5;
    read_frame("ovr read2", e, 0);
    acq_pulses(ACQ_NUM - 1);
    tick();
    check("ovr cnt restart frame_done", frame_done, 0);
    check("ovr cnt restart valid", rd_valid, 0);
    acq_pulses(1);
    swap_check("ovr cnt restart");
    read_frame("ovr read3", zero, 0);
    check("ovr sticky", overrun, 1);

    // Reset during readout aborts the frame and clears both banks.
    repeat (3) hit(6);
    repeat (2) hit(1);
    acq_pulses(ACQ_NUM);
    swap_check("rst");
    rd_ready = 1'b1;
    tick(); tick();
    check("rst pre bin", rd_bin, 2);
    res = 1'b1;
    #1;
    reset_outputs_check("rst async");
    exp_sel = 1'b0;
    tick();
    res = 1'b0;
    tick();
    hit(2);
    acq_pulses(ACQ_NUM);
    swap_check("rst f1");
    e = '0; e[2] = 4'd1;
    read_frame("rst f1", e, 0);
    acq_pulses(ACQ_NUM);
    swap_check("rst f2");
    read_frame("rst f2", zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
